// File: rtl/ds_pkg.sv
// Shared types and width helpers for the decimating capture controller.
package ds_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } ds_state_e;

  // Worst-case block sum of 2^max_log2 samples needs max_log2 extra bits.
  function automatic int acc_width(input int data_width, input int max_log2);
    return data_width + max_log2;
  endfunction

  localparam int DS_ACC_W_DEFAULT = acc_width(14, 8);

endpackage

// File: rtl/ds_accum.sv
// Block accumulator: sums 2^k signed samples, reports the closing sample and
// the block mean (arithmetic shift of the running sum including that sample).
module ds_accum
  import ds_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int MAX_LOG2   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  sample_en,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic [3:0]            k,
  output logic                  block_close,
  output logic [DATA_WIDTH-1:0] block_mean
);

  localparam int ACC_W = acc_width(DATA_WIDTH, MAX_LOG2);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_shift;
  logic [MAX_LOG2:0]       cnt;
  logic [MAX_LOG2:0]       last_idx;

  assign acc_sum     = acc + {{MAX_LOG2{sample[DATA_WIDTH-1]}}, sample};
  assign acc_shift   = acc_sum >>> k;
  assign block_mean  = acc_shift[DATA_WIDTH-1:0];
  assign last_idx    = (MAX_LOG2 + 1)'((1 << k) - 1);
  assign block_close = sample_en && (cnt == last_idx);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample_en) begin
      if (block_close) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ds_capture_ctrl.sv
// Capture sequencer for a decimating ADC front end (block-mean by 2^k).
// Optional rising-edge trigger in ARM is enabled by defining DS_CAPTURE_TRIG_EN.
//
// state  | meaning
// IDLE   | waiting for start
// ARM    | capture armed; waits one cycle, or for a trigger crossing
// ACC    | accumulating blocks and handing results downstream
// DONE   | requested number of transfers reached; done pulses here
module ds_capture_ctrl
  import ds_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int MAX_LOG2   = 8,
  parameter int CNT_W      = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [3:0]            log2_rate,
  input  logic [CNT_W-1:0]      num_samples,
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic                  out_ready,
`ifdef DS_CAPTURE_TRIG_EN
  input  logic [DATA_WIDTH-1:0] trig_level,
`endif
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  ds_state_e             state;
  logic [3:0]            k_lat;
  logic [3:0]            k_clamped;
  logic [CNT_W-1:0]      n_lat;
  logic [CNT_W-1:0]      xfer_cnt;
  logic                  active;
  logic                  xfer;
  logic                  last_xfer;
  logic                  arm_go;
  logic                  sample_en;
  logic                  acc_clear;
  logic                  block_close;
  logic [DATA_WIDTH-1:0] block_mean;

  assign k_clamped = (log2_rate > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : log2_rate;
  assign active    = (state == S_ARM) || (state == S_ACC);
  assign xfer      = out_valid && out_ready;
  assign last_xfer = (n_lat != '0) && (CNT_W'(xfer_cnt + 1'b1) == n_lat);
  assign acc_clear = !active || abort;

`ifdef DS_CAPTURE_TRIG_EN
  logic prev_below;
  logic crossing;
  // The crossing sample itself is the first one accumulated.
  assign crossing  = (state == S_ARM) && adc_valid && prev_below &&
                     ($signed(adc_data) >= $signed(trig_level));
  assign arm_go    = crossing;
  assign sample_en = !abort && adc_valid && ((state == S_ACC) || crossing);
`else
  assign arm_go    = 1'b1;
  assign sample_en = !abort && adc_valid && (state == S_ACC);
`endif

  ds_accum #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_LOG2   (MAX_LOG2)
  ) u_accum (
    .clk         (clk),
    .rst         (rst),
    .clear       (acc_clear),
    .sample_en   (sample_en),
    .sample      (adc_data),
    .k           (k_lat),
    .block_close (block_close),
    .block_mean  (block_mean)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k_lat     <= '0;
      n_lat     <= '0;
      xfer_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
`ifdef DS_CAPTURE_TRIG_EN
      prev_below <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_ARM;
            busy     <= 1'b1;
            k_lat    <= k_clamped;
            n_lat    <= num_samples;
            xfer_cnt <= '0;
            overrun  <= 1'b0;
`ifdef DS_CAPTURE_TRIG_EN
            prev_below <= 1'b0;
`endif
          end
        end
        S_ARM, S_ACC: begin
          if (abort) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end else begin
            if (state == S_ARM && arm_go) state <= S_ACC;
`ifdef DS_CAPTURE_TRIG_EN
            if (state == S_ARM && adc_valid)
              prev_below <= $signed(adc_data) < $signed(trig_level);
`endif
            if (xfer) xfer_cnt <= xfer_cnt + 1'b1;
            // The final transfer ends the capture; a block closing alongside it is not kept.
            if (xfer && last_xfer) begin
              state     <= S_DONE;
              done      <= 1'b1;
              out_valid <= 1'b0;
            end else if (block_close && (!out_valid || xfer)) begin
              out_data  <= block_mean;
              out_valid <= 1'b1;
            end else if (block_close) begin
              overrun <= 1'b1;
            end else if (xfer) begin
              out_valid <= 1'b0;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ds_capture_ctrl.sv
// Self-checking bench for ds_capture_ctrl: vector table, directed corner
// sequences and a randomized run against a queue-based block-mean model.
module tb_ds_capture_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [3:0]  log2_rate;
  logic [11:0] num_samples;
  logic        adc_valid;
  logic [13:0] adc_data;
  logic        out_ready;
  logic        out_valid;
  logic [13:0] out_data;
  logic        busy;
  logic        done;
  logic        overrun;
`ifdef DS_CAPTURE_TRIG_EN
  logic [13:0] trig_level;
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  ds_capture_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .log2_rate   (log2_rate),
    .num_samples (num_samples),
    .adc_valid   (adc_valid),
    .adc_data    (adc_data),
    .out_ready   (out_ready),
`ifdef DS_CAPTURE_TRIG_EN
    .trig_level  (trig_level),
`endif
    .out_valid   (out_valid),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input bit a, input int rate, input int num,
                       input bit v, input int d, input bit r);
    start       = s;
    abort       = a;
    log2_rate   = 4'(rate);
    num_samples = 12'(num);
    adc_valid   = v;
    adc_data    = 14'(d);
    out_ready   = r;
  endtask

  function automatic int sdata();
    return int'($signed(out_data));
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit start; int rate; int num; bit valid; int data; bit ready;
    bit e_valid; int e_data; bit e_busy; bit e_done;
  } vec_t;
  vec_t vt[$];

  task automatic add_vec(input bit s, input int rate, input int num, input bit v, input int d,
                         input bit ev, input int ed, input bit eb, input bit edn);
    vec_t x;
    x.start = s; x.rate = rate; x.num = num; x.valid = v; x.data = d; x.ready = 1'b1;
    x.e_valid = ev; x.e_data = ed; x.e_busy = eb; x.e_done = edn;
    vt.push_back(x);
  endtask

  // ---------------- reference model ----------------
  int  m_phase;  // 0 idle, 1 armed, 2 accumulating, 3 done
  int  m_k, m_n, m_xfers, m_data;
  bit  m_valid, m_over, m_done, m_prev_below;
  int  m_q[$];

  task automatic model_reset();
    m_phase = 0; m_k = 0; m_n = 0; m_xfers = 0; m_data = 0;
    m_valid = 0; m_over = 0; m_done = 0; m_prev_below = 0;
    m_q.delete();
  endtask

  function automatic int floor_div(input int sum, input int den);
    if (sum >= 0) return sum / den;
    return -((-sum + den - 1) / den);
  endfunction

  task automatic model_step(input int trig);
    bit xfer;
    bit closed;
    int mean;
    int d;
    int sum;
    xfer   = m_valid && out_ready;
    closed = 0;
    mean   = 0;
    d      = int'($signed(adc_data));
    m_done = 0;
    case (m_phase)
      0: if (start) begin
        m_phase = 1; m_k = (log2_rate > 8) ? 8 : int'(log2_rate);
        m_n = int'(num_samples); m_xfers = 0; m_over = 0; m_prev_below = 0;
        m_q.delete();
      end
      1, 2: if (abort) begin
        m_phase = 0; m_valid = 0; m_q.delete();
      end else begin
        if (m_phase == 1) begin
          if (!TRIG) m_phase = 2;
          else if (adc_valid) begin
            if (m_prev_below && d >= trig) begin
              m_phase = 2;
              m_q.push_back(d);
            end else m_prev_below = (d < trig);
          end
        end else if (adc_valid) m_q.push_back(d);
        if (m_q.size() == (1 << m_k)) begin
          sum = 0;
          foreach (m_q[i]) sum += m_q[i];
          mean = floor_div(sum, 1 << m_k);
          closed = 1;
          m_q.delete();
        end
        if (xfer) m_xfers++;
        if (xfer && m_n != 0 && m_xfers == m_n) begin
          m_phase = 3; m_valid = 0;
        end else if (closed) begin
          if (!m_valid || xfer) begin m_data = mean; m_valid = 1; end
          else m_over = 1;
        end else if (xfer) m_valid = 0;
      end
      default: m_phase = 0;
    endcase
    m_done = (m_phase == 3);
  endtask

  // Captures one block of a constant value with num_samples=1.
  task automatic capture_const(input string name, input int rate, input int n, input int val,
                               input int exp_mean);
    drive(1, 0, rate, 1, 0, 0, 1); tick();
    drive(0, 0, rate, 1, 0, 0, 1); tick();
    for (int i = 0; i < n; i++) begin
      drive(0, 0, rate, 1, 1, val, 1); tick();
      if (i == n - 2) check({name, "_early_valid"}, out_valid, 0);
    end
    check({name, "_valid"}, out_valid, 1);
    check({name, "_data"}, sdata(), exp_mean);
    drive(0, 0, rate, 1, 0, 0, 1); tick();
    check({name, "_done"}, done, 1);
    tick();
    check({name, "_idle"}, busy, 0);
  endtask

  initial begin
    int pat[4];
    pat[0] = 4; pat[1] = 8; pat[2] = -4; pat[3] = 0;
`ifdef DS_CAPTURE_TRIG_EN
    trig_level = '0;
`endif
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_out_data", sdata(), 0);

`ifndef DS_CAPTURE_TRIG_EN
    // k=2, three outputs of mean(4,8,-4,0)=2, then done.
    add_vec(1, 2, 3, 0, 0, 0, 0, 1, 0);
    add_vec(0, 2, 3, 0, 0, 0, 0, 1, 0);
    for (int b = 0; b < 3; b++)
      for (int j = 0; j < 4; j++)
        add_vec(0, 2, 3, 1, pat[j], (j == 3) ? 1'b1 : 1'b0, (b == 0 && j < 3) ? 0 : 2, 1, 0);
    add_vec(0, 2, 3, 1, 4, 0, 2, 1, 1);
    add_vec(0, 2, 3, 1, 8, 0, 2, 0, 0);
    add_vec(0, 2, 3, 0, 0, 0, 2, 0, 0);
    foreach (vt[i]) begin
      drive(vt[i].start, 0, vt[i].rate, vt[i].num, vt[i].valid, vt[i].data, vt[i].ready);
      tick();
      check($sformatf("vec%0d_valid", i), out_valid, vt[i].e_valid);
      check($sformatf("vec%0d_data", i), sdata(), vt[i].e_data);
      check($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
      check($sformatf("vec%0d_done", i), done, vt[i].e_done);
    end

    // k=0 continuous passthrough, then abort.
    drive(1, 0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 1, i, 1); tick();
      check($sformatf("ramp%0d_valid", i), out_valid, 1);
      check($sformatf("ramp%0d_data", i), sdata(), i);
    end
    drive(0, 1, 0, 0, 0, 0, 1); tick();
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_done", done, 0);
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    check("abort_done_after", done, 0);

    // k=1, stalled downstream: one output held, overrun, transfers counted once.
    drive(1, 0, 1, 2, 0, 0, 0); tick();
    drive(0, 0, 1, 2, 0, 0, 0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 2, 1, 100, 0); tick();
      if (i == 1) check("ovr_first_overrun", overrun, 0);
    end
    check("ovr_valid", out_valid, 1);
    check("ovr_data", sdata(), 100);
    check("ovr_flag", overrun, 1);
    drive(0, 0, 1, 2, 0, 0, 1); tick();
    check("ovr_xfer1_valid", out_valid, 0);
    check("ovr_xfer1_busy", busy, 1);
    check("ovr_xfer1_done", done, 0);
    drive(0, 0, 1, 2, 1, 50, 1); tick();
    drive(0, 0, 1, 2, 1, 50, 1); tick();
    check("ovr_blk2_data", sdata(), 50);
    drive(0, 0, 1, 2, 0, 0, 1); tick();
    check("ovr_xfer2_done", done, 1);
    tick();
    check("ovr_sticky", overrun, 1);
    drive(1, 0, 0, 0, 0, 0, 1); tick();
    check("ovr_cleared_by_start", overrun, 0);
    drive(0, 1, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 1); tick();
`endif

    capture_const("neg1_k3", 3, 8, -1, -1);
    capture_const("min_k3", 3, 8, -8192, -8192);
    capture_const("min_clamp", 15, 256, -8192, -8192);
    capture_const("max_clamp", 9, 256, 8191, 8191);

    // rst mid-block: the next capture must not see pre-reset samples.
    drive(1, 0, 4, 1, 0, 0, 1); tick();
    drive(0, 0, 4, 1, 0, 0, 1); tick();
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 4, 1, 1, 1000, 1); tick();
    end
    rst = 1'b1;
    drive(0, 0, 4, 1, 0, 0, 1); tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_valid", out_valid, 0);
    capture_const("post_rst_k4", 4, 16, 16, 16);

`ifdef DS_CAPTURE_TRIG_EN
    trig_level = 14'(0);
    drive(1, 0, 1, 1, 0, 0, 1); tick();
    drive(0, 0, 1, 1, 1, -5, 1); tick();
    drive(0, 0, 1, 1, 1, -3, 1); tick();
    drive(0, 0, 1, 1, 1, 2, 1); tick();
    check("trig_no_early", out_valid, 0);
    drive(0, 0, 1, 1, 1, 6, 1); tick();
    check("trig_valid", out_valid, 1);
    check("trig_data", sdata(), 4);
    drive(0, 0, 1, 1, 0, 0, 1); tick();
    check("trig_done", done, 1);
    tick();
`endif

    // Randomized run against the model.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    rst = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int rate;
      rate = ($urandom_range(0, 19) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 3));
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0, rate,
            int'($urandom_range(0, 4)), $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 16383)) - 8192, $urandom_range(0, 2) != 0);
      tick();
      model_step(0);
      check("rnd_valid", out_valid, m_valid);
      check("rnd_data", sdata(), m_data);
      check("rnd_busy", busy, m_phase != 0);
      check("rnd_done", done, m_done);
      check("rnd_overrun", overrun, m_over);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ds_capture_ctrl.md
DS_CAPTURE_CTRL -- requirements
Module: ds_capture_ctrl

Interface
REQ-001 SHALL provide parameters: DATA_WIDTH, default 14, sample width; MAX_LOG2, default 8, largest decimation exponent; CNT_W, default 12, sample-count width.
REQ-002 SHALL provide ports as follows.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse; begins a capture.
- abort  in  1  one-cycle pulse; ends a capture.
- log2_rate  in  4  decimation exponent k; factor is 2^k.
- num_samples  in  CNT_W  decimated samples to emit; 0 means continuous.
- adc_valid  in  1  input sample strobe.
- adc_data  in  DATA_WIDTH  signed two's-complement sample.
- out_valid  out  1  decimated sample available.
- out_data  out  DATA_WIDTH  signed block mean.
- out_ready  in  1  downstream accepts; transfer occurs when out_valid and out_ready are both high.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a capture completes.
- overrun  out  1  sticky; a block was dropped.

Function
REQ-003 SHALL implement states IDLE, ARM, ACC and DONE.
REQ-004 SHALL move from IDLE to ARM on start, latching log2_rate and num_samples; start SHALL be ignored outside IDLE.
REQ-005 SHALL clamp a latched log2_rate above MAX_LOG2 to MAX_LOG2.
REQ-006 SHALL accumulate, in ACC, each adc_data with adc_valid high into a signed accumulator of width DATA_WIDTH+MAX_LOG2, sign-extending each sample.
REQ-007 SHALL treat the sample that is the 2^k-th of a block as closing that block.
  - The block result is the arithmetic right shift of the accumulator by k.
  - The next block starts with the following valid sample; no sample is lost or double-counted.
REQ-008 SHALL load out_data and set out_valid on the clock edge after the closing sample; k=0 therefore gives passthrough with 1-cycle latency.
REQ-009 SHALL hold out_data and out_valid stable until a transfer, then clear out_valid.
  - If a new block closes in the same cycle as a transfer, the new result SHALL load and out_valid SHALL stay high.
REQ-010 SHALL drop a block that closes while out_valid is high with no transfer, set overrun, leave out_data unchanged, and continue accumulating.
REQ-011 SHALL count transfers, not dropped blocks; at the num_samples-th transfer (num_samples nonzero) SHALL go to DONE.
REQ-012 SHALL stay in DONE for one cycle, assert done in that cycle, then return to IDLE.
REQ-013 SHALL handle abort in ARM or ACC as follows:
  - next state is IDLE;
  - the partial block is discarded;
  - out_valid clears;
  - done is not asserted.
  Abort in IDLE or DONE SHALL have no effect.
REQ-014 SHALL give abort priority over block completion in the same cycle.
REQ-015 SHALL clear overrun only on rst or on an accepted start.

Reset
REQ-016 SHALL, on rst, drive state to IDLE and force out_valid, busy, done and overrun to 0.
REQ-017 SHALL, on rst, clear the accumulator, block counter, sample counter and out_data to 0.
REQ-018 SHALL let rst mid-capture abandon all work within one cycle, with no done pulse.

Configuration
REQ-019 SHALL, with DS_CAPTURE_TRIG_EN defined, add input trig_level (DATA_WIDTH, signed).
  - ARM SHALL wait for a rising crossing: a valid sample >= trig_level whose preceding valid sample was < trig_level.
  - The crossing sample SHALL be the first sample accumulated.
REQ-020 SHALL, without DS_CAPTURE_TRIG_EN, omit trig_level and pass from ARM to ACC unconditionally after one cycle; the first valid sample in ACC is the first accumulated.

Structure
REQ-021 SHALL place the state enumeration and the accumulator-width constant in shared package ds_pkg.
REQ-022 SHALL put the accumulate/shift datapath in one sub-module, ds_accum, with the FSM and counters in ds_capture_ctrl.

Verification
REQ-023 SHALL cover these directed scenarios:
- k=2, num_samples=3, out_ready=1, adc_data 4,8,-4,0 repeated → three outputs of 2, then done, then busy=0.
- k=0, continuous, ramp 0..9 → out_data equals each input 1 cycle later; abort → IDLE, no done.
- k=1, out_ready=0 for 6 valid samples of 100 → one output of 100 held, overrun=1, later transfer counted once.
- Input -1 for every sample with k=3 → out_data = -1; input -8192 for every sample → out_data = -8192; no overflow.
- rst asserted mid-block with k=4 → next capture's first output excludes pre-reset samples.
- DS_CAPTURE_TRIG_EN, trig_level=0, input -5,-3,2,6 with k=1 → first output 4 (mean of 2 and 6).
